// File: rtl/point_spawner_pkg.sv
// Shared arena constants, spawn FSM encoding and the hit-radius helper
// used by the pickup manager.
package point_spawner_pkg;

  localparam int GRID_PITCH  = 32;
  localparam int GRID_COLS   = 31;
  localparam int GRID_ROWS   = 23;
  localparam int POINT_SIZE  = 8;
  localparam int PLAYER_SIZE = 12;

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_PLACE} spawn_state_t;

  // Signed 11-bit distance so a player near the map edge never wraps into a hit.
  function automatic logic within_r(input logic [9:0] a, input logic [9:0] b, input int r);
    logic signed [10:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) d = -d;
    return (int'(d) <= r);
  endfunction

endpackage

// File: rtl/lfsr_cell_gen.sv
// Free-running 16-bit Fibonacci LFSR mapped onto a grid cell centre; supplies
// the placement candidate to the terrain collision block.
module lfsr_cell_gen
  import point_spawner_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] cand_x,
  output logic [9:0] cand_y
);

  logic [15:0] lfsr;
  logic        fb;
  logic [7:0]  col;
  logic [7:0]  row;

  // Taps 16,14,13,11
  assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk) begin
    if (rst) lfsr <= SEED;
    else     lfsr <= {lfsr[14:0], fb};
  end

  always_comb begin
    col    = 8'(lfsr[7:0]  % 8'(GRID_COLS));
    row    = 8'(lfsr[15:8] % 8'(GRID_ROWS));
    cand_x = 10'((10'(col) + 10'd1) * 10'(GRID_PITCH));
    cand_y = 10'((10'(row) + 10'd1) * 10'(GRID_PITCH));
  end

endmodule

// File: rtl/point_spawner.sv
// Multi-slot collectible manager: pickup detection, saturating scores,
// per-slot cooldowns and an LFSR-driven respawn search.
module point_spawner
  import point_spawner_pkg::*;
#(
  parameter int          NUM_POINTS = 4,
  parameter int          SCORE_W    = 5,
  parameter int          COOLDOWN   = 10000,
  parameter int          MAX_TRIES  = 64,
  parameter int          RETRY_GAP  = 16,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          INIT_X     = 512,
  parameter int          INIT_Y     = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic [1:0][9:0]                  player_x,
  input  logic [1:0][9:0]                  player_y,
  output logic [9:0]                       cand_x,
  output logic [9:0]                       cand_y,
  input  logic                             cand_blocked,
  output logic [NUM_POINTS-1:0][9:0]       point_x,
  output logic [NUM_POINTS-1:0][9:0]       point_y,
  output logic [NUM_POINTS-1:0]            point_valid,
  output logic [1:0][SCORE_W-1:0]          score,
  output logic [1:0]                       pickup_pulse
);

  localparam int HIT_R  = POINT_SIZE + PLAYER_SIZE;
  localparam int CD_MAX = (COOLDOWN > RETRY_GAP) ? COOLDOWN : RETRY_GAP;
  localparam int CD_W   = $clog2(CD_MAX + 1);
  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int IDX_W  = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;
  localparam int SUM_W  = SCORE_W + 4;

  localparam logic [9:0] START0_X = 10'(GRID_PITCH);
  localparam logic [9:0] START0_Y = 10'(GRID_PITCH);
  localparam logic [9:0] START1_X = 10'(GRID_COLS * GRID_PITCH);
  localparam logic [9:0] START1_Y = 10'(GRID_ROWS * GRID_PITCH);

  spawn_state_t                      state;
  logic [NUM_POINTS-1:0][CD_W-1:0]   cd;
  logic [TRY_W-1:0]                  tries;
  logic [IDX_W-1:0]                  slot;
  logic [9:0]                        lat_x, lat_y;

  logic [1:0][NUM_POINTS-1:0]        hit;
  logic [1:0][NUM_POINTS-1:0]        take;
  logic [1:0][3:0]                   cnt;
  logic [1:0][SUM_W-1:0]             sum;
  logic [1:0][SCORE_W-1:0]           score_nxt;
  logic [NUM_POINTS-1:0]             eligible;
  logic                              any_elig;
  logic [IDX_W-1:0]                  elig_idx;
  logic                              on_slot, on_player, on_start, reject;

  lfsr_cell_gen #(.SEED(SEED)) u_gen (
    .clk    (clk),
    .rst    (rst),
    .cand_x (cand_x),
    .cand_y (cand_y)
  );

  always_comb begin
    hit       = '0;
    cnt       = '0;
    sum       = '0;
    score_nxt = score;
    for (int unsigned p = 0; p < 2; p++) begin
      for (int unsigned i = 0; i < NUM_POINTS; i++) begin
        hit[p][i] = point_valid[i] && within_r(player_x[p], point_x[i], HIT_R)
                                   && within_r(player_y[p], point_y[i], HIT_R);
      end
    end
    // P1 owns any slot both players touch in the same cycle.
    take[0] = hit[0];
    take[1] = hit[1] & ~hit[0];
    for (int unsigned p = 0; p < 2; p++) begin
      for (int unsigned i = 0; i < NUM_POINTS; i++) cnt[p] = cnt[p] + 4'(take[p][i]);
      sum[p] = SUM_W'(score[p]) + SUM_W'(cnt[p]);
      score_nxt[p] = (sum[p] > SUM_W'({SCORE_W{1'b1}})) ? '1 : sum[p][SCORE_W-1:0];
    end
  end

  always_comb begin
    any_elig = 1'b0;
    elig_idx = '0;
    on_slot  = 1'b0;
    for (int unsigned i = 0; i < NUM_POINTS; i++) begin
      eligible[i] = !point_valid[i] && (cd[i] == '0);
      if (eligible[i] && !any_elig) begin
        any_elig = 1'b1;
        elig_idx = IDX_W'(i);
      end
      if (point_valid[i] && point_x[i] == cand_x && point_y[i] == cand_y) on_slot = 1'b1;
    end
    on_player = 1'b0;
    for (int unsigned p = 0; p < 2; p++) begin
      if (within_r(player_x[p], cand_x, HIT_R) && within_r(player_y[p], cand_y, HIT_R))
        on_player = 1'b1;
    end
    on_start = (cand_x == START0_X && cand_y == START0_Y) ||
               (cand_x == START1_X && cand_y == START1_Y);
    reject   = cand_blocked || on_start || on_slot || on_player;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      point_valid  <= NUM_POINTS'(1);
      point_x      <= '0;
      point_y      <= '0;
      point_x[0]   <= 10'(INIT_X);
      point_y[0]   <= 10'(INIT_Y);
      cd           <= '0;
      score        <= '0;
      pickup_pulse <= '0;
      state        <= S_IDLE;
      tries        <= '0;
      slot         <= '0;
      lat_x        <= '0;
      lat_y        <= '0;
    end else begin
      pickup_pulse <= '0;
      if (enable) begin
        for (int unsigned i = 0; i < NUM_POINTS; i++) begin
          if (take[0][i] || take[1][i]) begin
            point_valid[i] <= 1'b0;
            cd[i]          <= CD_W'(COOLDOWN);
          end else if (cd[i] != '0) begin
            cd[i] <= cd[i] - 1'b1;
          end
        end
        score        <= score_nxt;
        pickup_pulse <= {|take[1], |take[0]};

        // The slot under search is empty, so these writes never collide with a pickup.
        case (state)
          S_IDLE: begin
            if (any_elig) begin
              slot  <= elig_idx;
              tries <= '0;
              state <= S_SEARCH;
            end
          end
          S_SEARCH: begin
            if (!reject) begin
              lat_x <= cand_x;
              lat_y <= cand_y;
              state <= S_PLACE;
            end else if (tries == TRY_W'(MAX_TRIES - 1)) begin
              cd[slot] <= CD_W'(RETRY_GAP);
              state    <= S_IDLE;
            end else begin
              tries <= tries + 1'b1;
            end
          end
          S_PLACE: begin
            point_x[slot]     <= lat_x;
            point_y[slot]     <= lat_y;
            point_valid[slot] <= 1'b1;
            state             <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_point_spawner.sv
// Directed bench for point_spawner: reset, spawning, pickups, priority,
// blocked search timing, saturation, mid-search reset and edge hit radius.
module tb_point_spawner;
  import point_spawner_pkg::*;

  localparam int NP    = 4;
  localparam int SW    = 5;
  localparam int CDN   = 40;
  localparam int TRIES = 64;
  localparam int GAP   = 16;
  localparam int IX    = 32;
  localparam int IY    = 64;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                enable = 1'b1;
  logic [1:0][9:0]     player_x;
  logic [1:0][9:0]     player_y;
  logic [9:0]          cand_x, cand_y;
  logic                cand_blocked = 1'b0;
  logic [NP-1:0][9:0]  point_x, point_y;
  logic [NP-1:0]       point_valid;
  logic [1:0][SW-1:0]  score;
  logic [1:0]          pickup_pulse;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  point_spawner #(
    .NUM_POINTS(NP), .SCORE_W(SW), .COOLDOWN(CDN), .MAX_TRIES(TRIES),
    .RETRY_GAP(GAP), .SEED(16'hACE1), .INIT_X(IX), .INIT_Y(IY)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .player_x(player_x), .player_y(player_y),
    .cand_x(cand_x), .cand_y(cand_y), .cand_blocked(cand_blocked),
    .point_x(point_x), .point_y(point_y), .point_valid(point_valid),
    .score(score), .pickup_pulse(pickup_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic park_players();
    player_x[0] = 10'd32;  player_y[0] = 10'd32;
    player_x[1] = 10'd992; player_y[1] = 10'd736;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_all_valid(input int bound, output bit ok);
    int n = 0;
    while (point_valid !== 4'hF && n < bound) begin tick(); n++; end
    ok = (point_valid === 4'hF);
  endtask

  task automatic wait_state(input spawn_state_t s, input bit eq, input int bound, output bit ok);
    int n = 0;
    while (((dut.state == s) != eq) && n < bound) begin tick(); n++; end
    ok = ((dut.state == s) == eq);
  endtask

  task automatic test_reset();
    bit ok;
    bit bad;
    park_players();
    enable = 1'b1;
    cand_blocked = 1'b0;
    do_reset();
    tests++; if (point_valid !== 4'b0001) begin fails++; $display("FAIL reset_valid got %b want 0001", point_valid); end
    tests++; if (point_x[0] !== 10'd32 || point_y[0] !== 10'd64) begin fails++; $display("FAIL reset_slot0 got (%0d,%0d) want (32,64)", point_x[0], point_y[0]); end
    tests++; if (point_x[1] !== 10'd0 || point_y[3] !== 10'd0) begin fails++; $display("FAIL reset_coords got x1=%0d y3=%0d want 0", point_x[1], point_y[3]); end
    tests++; if (score !== '0 || pickup_pulse !== 2'b00) begin fails++; $display("FAIL reset_score got score=%h pulse=%b want 0", score, pickup_pulse); end
    wait_all_valid(4 * (TRIES + 2), ok);
    tests++; if (!ok) begin fails++; $display("FAIL fill_slots got valid=%b want 1111", point_valid); end
    bad = 1'b0;
    for (int i = 0; i < NP; i++) begin
      if ((point_x[i] == 10'd32 && point_y[i] == 10'd32) || (point_x[i] == 10'd992 && point_y[i] == 10'd736)) bad = 1'b1;
      if (point_x[i][4:0] != 5'd0 || point_y[i][4:0] != 5'd0 || point_x[i] == 10'd0 || point_y[i] == 10'd0) bad = 1'b1;
      for (int j = i + 1; j < NP; j++)
        if (point_x[i] == point_x[j] && point_y[i] == point_y[j]) bad = 1'b1;
    end
    tests++; if (bad) begin fails++; $display("FAIL slot_props got bad=1 want distinct grid cells off start cells"); end
  endtask

  task automatic test_enable();
    park_players();
    enable = 1'b0;
    do_reset();
    player_x[0] = 10'd32; player_y[0] = 10'd64;
    repeat (3) tick();
    tests++; if (score[0] !== 5'd0 || pickup_pulse !== 2'b00 || point_valid !== 4'b0001) begin fails++;
      $display("FAIL enable_hold got score=%0d pulse=%b valid=%b want 0 00 0001", score[0], pickup_pulse, point_valid); end
    enable = 1'b1;
    tick();
    tests++; if (score[0] !== 5'd1 || pickup_pulse !== 2'b01) begin fails++;
      $display("FAIL enable_resume got score=%0d pulse=%b want 1 01", score[0], pickup_pulse); end
    park_players();
  endtask

  task automatic test_pickup();
    bit ok;
    int n;
    park_players();
    do_reset();
    wait_all_valid(4 * (TRIES + 2), ok);
    player_x[0] = 10'd32; player_y[0] = 10'd64;
    tick();
    tests++; if (score[0] !== 5'd1 || pickup_pulse !== 2'b01 || point_valid[0] !== 1'b0) begin fails++;
      $display("FAIL pickup got score=%0d pulse=%b v0=%b want 1 01 0", score[0], pickup_pulse, point_valid[0]); end
    tick();
    n = 1;
    tests++; if (pickup_pulse !== 2'b00 || score[0] !== 5'd1) begin fails++;
      $display("FAIL pickup_once got score=%0d pulse=%b want 1 00", score[0], pickup_pulse); end
    while (!point_valid[0] && n < CDN + TRIES + 10) begin tick(); n++; end
    tests++; if (!point_valid[0] || n < CDN + 2) begin fails++;
      $display("FAIL respawn_time got valid=%b after %0d cycles want valid, >= %0d", point_valid[0], n, CDN + 2); end
    tests++; if ((point_x[0] == 10'd32 && point_y[0] == 10'd64) || score[0] !== 5'd1) begin fails++;
      $display("FAIL respawn_pos got (%0d,%0d) score=%0d want off P1, score 1", point_x[0], point_y[0], score[0]); end
    park_players();
  endtask

  task automatic test_both();
    bit ok;
    park_players();
    do_reset();
    player_x[0] = 10'd32; player_y[0] = 10'd64;
    player_x[1] = 10'd32; player_y[1] = 10'd64;
    tick();
    tests++; if (score[0] !== 5'd1 || score[1] !== 5'd0 || pickup_pulse !== 2'b01) begin fails++;
      $display("FAIL shared_slot got s0=%0d s1=%0d pulse=%b want 1 0 01", score[0], score[1], pickup_pulse); end
    park_players();
    wait_all_valid(4 * (TRIES + 2), ok);
    player_x[0] = point_x[0]; player_y[0] = point_y[0];
    player_x[1] = point_x[1]; player_y[1] = point_y[1];
    tick();
    tests++; if (score[0] !== 5'd2 || score[1] !== 5'd1 || pickup_pulse !== 2'b11) begin fails++;
      $display("FAIL split_slots got s0=%0d s1=%0d pulse=%b want 2 1 11", score[0], score[1], pickup_pulse); end
    park_players();
  endtask

  task automatic test_blocked();
    bit ok, ok2, ok3;
    int t0, n;
    park_players();
    do_reset();
    wait_all_valid(4 * (TRIES + 2), ok);
    cand_blocked = 1'b1;
    player_x[0] = 10'd32; player_y[0] = 10'd64;
    tick();
    park_players();
    wait_state(S_SEARCH, 1'b1, 200, ok);
    t0 = cyc;
    wait_state(S_SEARCH, 1'b0, 100, ok2);
    wait_state(S_SEARCH, 1'b1, 100, ok3);
    tests++; if (!(ok && ok2 && ok3) || (cyc - t0) != TRIES + GAP + 1) begin fails++;
      $display("FAIL retry_period got %0d cycles want %0d", cyc - t0, TRIES + GAP + 1); end
    tests++; if (point_valid[0] !== 1'b0) begin fails++; $display("FAIL blocked_stays got v0=%b want 0", point_valid[0]); end
    cand_blocked = 1'b0;
    n = 0;
    while (!point_valid[0] && n < TRIES + 2) begin tick(); n++; end
    tests++; if (!point_valid[0]) begin fails++; $display("FAIL unblock_place got v0=%b after %0d want 1", point_valid[0], n); end
  endtask

  task automatic test_saturate();
    bit ok;
    int sel, exp_s;
    park_players();
    do_reset();
    for (int k = 1; k <= 33; k++) begin
      int n = 0;
      while (point_valid === 4'b0000 && n < 200) begin tick(); n++; end
      sel = 0;
      for (int i = NP - 1; i >= 0; i--) if (point_valid[i]) sel = i;
      player_x[0] = point_x[sel]; player_y[0] = point_y[sel];
      tick();
      exp_s = (k > 31) ? 31 : k;
      tests++; if (score[0] !== 5'(exp_s) || pickup_pulse[0] !== 1'b1) begin fails++;
        $display("FAIL saturate k=%0d got score=%0d pulse=%b want %0d 1", k, score[0], pickup_pulse[0], exp_s); end
      park_players();
      tick();
    end
    ok = 1'b1;
  endtask

  task automatic test_rst_search();
    bit ok;
    park_players();
    do_reset();
    wait_all_valid(4 * (TRIES + 2), ok);
    cand_blocked = 1'b1;
    player_x[0] = 10'd32; player_y[0] = 10'd64;
    tick();
    park_players();
    wait_state(S_SEARCH, 1'b1, 200, ok);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cand_blocked = 1'b0;
    tests++; if (!ok || dut.state != S_IDLE || point_valid !== 4'b0001 || point_x[0] !== 10'd32 || point_y[0] !== 10'd64) begin fails++;
      $display("FAIL mid_search_rst got state=%0d valid=%b slot0=(%0d,%0d) want 0 0001 (32,64)", dut.state, point_valid, point_x[0], point_y[0]); end
    tests++; if (score !== '0 || pickup_pulse !== 2'b00) begin fails++;
      $display("FAIL mid_search_score got score=%h pulse=%b want 0", score, pickup_pulse); end
  endtask

  task automatic test_edge();
    player_x[0] = 10'd0; player_y[0] = 10'd64;
    repeat (2) tick();
    tests++; if (pickup_pulse !== 2'b00 || score[0] !== 5'd0 || point_valid[0] !== 1'b1) begin fails++;
      $display("FAIL edge_x0 got pulse=%b score=%0d v0=%b want 00 0 1", pickup_pulse, score[0], point_valid[0]); end
    player_x[0] = 10'd11;
    repeat (2) tick();
    tests++; if (pickup_pulse !== 2'b00 || score[0] !== 5'd0) begin fails++;
      $display("FAIL edge_r21 got pulse=%b score=%0d want 00 0", pickup_pulse, score[0]); end
    player_x[0] = 10'd12;
    tick();
    tests++; if (pickup_pulse !== 2'b01 || score[0] !== 5'd1) begin fails++;
      $display("FAIL edge_r20 got pulse=%b score=%0d want 01 1", pickup_pulse, score[0]); end
    park_players();
  endtask

  initial begin
    park_players();
    test_reset();
    test_enable();
    test_pickup();
    test_both();
    test_blocked();
    test_saturate();
    test_rst_search();
    test_edge();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
